// File: rtl/rounding_pack_unit_if.sv
// Handshake and data bundle for the FP32 round-and-pack stage.
// slave  : seen from the rounding_pack_unit itself.
// master : seen from the environment that feeds and drains the unit.
interface rounding_pack_unit_if #(
  parameter int SIZE_DATA = 28,
  parameter int SIZE_EXP  = 10
);

  // Upstream side (from the normalization stage)
  logic                       i_valid;
  logic                       o_ready;
  logic                       i_sign;
  logic signed [SIZE_EXP-1:0] i_exponent;
  logic [SIZE_DATA-1:0]       i_mantissa;
  logic                       i_zero_flag;
  logic                       i_nan_flag;
  logic                       i_inf_flag;

  // Downstream side
  logic                       o_valid;
  logic                       i_ready;
  logic [31:0]                o_result;

  // Sticky exception flags
  logic                       i_flag_clr;
  logic                       o_overflow;
  logic                       o_underflow;
  logic                       o_inexact;

  modport slave (
    input  i_valid, i_sign, i_exponent, i_mantissa,
    input  i_zero_flag, i_nan_flag, i_inf_flag,
    input  i_ready, i_flag_clr,
    output o_ready, o_valid, o_result,
    output o_overflow, o_underflow, o_inexact
  );

  modport master (
    output i_valid, i_sign, i_exponent, i_mantissa,
    output i_zero_flag, i_nan_flag, i_inf_flag,
    output i_ready, i_flag_clr,
    input  o_ready, o_valid, o_result,
    input  o_overflow, o_underflow, o_inexact
  );

endinterface

// File: rtl/rounding_pack_unit.sv
// Two-stage FP32 round-to-nearest-even and pack stage.
// Stage 1 rounds the 28-bit normalized mantissa; stage 2 absorbs the rounding
// carry, resolves specials / overflow / underflow and packs the IEEE-754 word.
// Valid/ready with full backpressure, no skid buffer; sticky exception flags.
module rounding_pack_unit #(
  parameter int SIZE_DATA = 28,
  parameter int SIZE_EXP  = 10
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  rounding_pack_unit_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                       s1_valid_q,   s1_valid_d;
  logic                       s1_sign_q,    s1_sign_d;
  logic signed [SIZE_EXP-1:0] s1_exp_q,     s1_exp_d;
  logic [24:0]                s1_sum_q,     s1_sum_d;
  logic                       s1_inexact_q, s1_inexact_d;
  logic                       s1_nan_q,     s1_nan_d;
  logic                       s1_inf_q,     s1_inf_d;
  logic                       s1_zero_q,    s1_zero_d;

  logic                       o_valid_q,    o_valid_d;
  logic [31:0]                result_q,     result_d;
  logic                       ev_ovf_q,     ev_ovf_d;
  logic                       ev_unf_q,     ev_unf_d;
  logic                       ev_inx_q,     ev_inx_d;

  logic                       ovf_q,        ovf_d;
  logic                       unf_q,        unf_d;
  logic                       inx_q,        inx_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic adv1, adv2, accept, retire;

  // Stage advance: stage 2 moves when empty or drained, stage 1 when it can push
  always_comb begin
    adv2   = !o_valid_q | bus.i_ready;
    adv1   = !s1_valid_q | adv2;
    accept = bus.i_valid & adv1;
    retire = o_valid_q & bus.i_ready;
  end

  assign bus.o_ready = adv1;

  // ---------------------------------------------------------------------------
  // Stage 1: round to nearest, ties to even
  // ---------------------------------------------------------------------------
  logic        rnd_lsb, rnd_guard, rnd_sticky, rnd_inc;
  logic [24:0] rnd_sum;

  // Round the incoming mantissa and load the stage-1 register on accept
  always_comb begin
    rnd_lsb    = bus.i_mantissa[4];
    rnd_guard  = bus.i_mantissa[3];
    rnd_sticky = |bus.i_mantissa[2:0];
    rnd_inc    = rnd_guard & (rnd_sticky | rnd_lsb);
    rnd_sum    = {1'b0, bus.i_mantissa[27:4]} + 25'(rnd_inc);

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_sum_d     = s1_sum_q;
    s1_inexact_d = s1_inexact_q;
    s1_nan_d     = s1_nan_q;
    s1_inf_d     = s1_inf_q;
    s1_zero_d    = s1_zero_q;

    if (adv1) s1_valid_d = bus.i_valid;
    if (accept) begin
      s1_sign_d    = bus.i_sign;
      s1_exp_d     = bus.i_exponent;
      s1_sum_d     = rnd_sum;
      s1_inexact_d = rnd_guard | rnd_sticky;
      s1_nan_d     = bus.i_nan_flag;
      s1_inf_d     = bus.i_inf_flag;
      s1_zero_d    = bus.i_zero_flag;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: carry adjust, range check, pack
  // ---------------------------------------------------------------------------
  logic signed [SIZE_EXP:0] exp_r;
  logic [22:0]              frac;
  logic [31:0]              pack_res;
  logic                     pack_ovf, pack_unf, pack_inx;

  // Resolve the packed word and its exception events by priority
  always_comb begin
    // One extra bit keeps exp + carry from wrapping at the top of the range
    exp_r = {s1_exp_q[SIZE_EXP-1], s1_exp_q} + {{SIZE_EXP{1'b0}}, s1_sum_q[24]};
    frac  = s1_sum_q[24] ? s1_sum_q[23:1] : s1_sum_q[22:0];

    pack_res = {s1_sign_q, exp_r[7:0], frac};
    pack_ovf = 1'b0;
    pack_unf = 1'b0;
    pack_inx = s1_inexact_q;

    if (s1_nan_q) begin
      pack_res = 32'h7FC0_0000;
      pack_inx = 1'b0;
    end else if (s1_inf_q) begin
      pack_res = {s1_sign_q, 8'hFF, 23'h0};
      pack_inx = 1'b0;
    end else if (s1_zero_q) begin
      pack_res = {s1_sign_q, 31'h0};
      pack_inx = 1'b0;
    end else if (exp_r <= 0) begin
      // No subnormal support: flush to signed zero
      pack_res = {s1_sign_q, 31'h0};
      pack_unf = 1'b1;
      pack_inx = 1'b1;
    end else if (exp_r >= 255) begin
      pack_res = {s1_sign_q, 8'hFF, 23'h0};
      pack_ovf = 1'b1;
      pack_inx = 1'b1;
    end

    o_valid_d = o_valid_q;
    result_d  = result_q;
    ev_ovf_d  = ev_ovf_q;
    ev_unf_d  = ev_unf_q;
    ev_inx_d  = ev_inx_q;

    if (adv2) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = pack_res;
        ev_ovf_d = pack_ovf;
        ev_unf_d = pack_unf;
        ev_inx_d = pack_inx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: clear first, then OR in the retiring beat's events
  // ---------------------------------------------------------------------------
  always_comb begin
    ovf_d = (bus.i_flag_clr ? 1'b0 : ovf_q) | (retire & ev_ovf_q);
    unf_d = (bus.i_flag_clr ? 1'b0 : unf_q) | (retire & ev_unf_q);
    inx_d = (bus.i_flag_clr ? 1'b0 : inx_q) | (retire & ev_inx_q);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // All pipeline and flag state, reset asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: data registers are reset along with the valid bits so that
      // o_result reads 0 out of reset and stage 1 never holds X.
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_sum_q     <= '0;
      s1_inexact_q <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_inf_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      o_valid_q    <= 1'b0;
      result_q     <= '0;
      ev_ovf_q     <= 1'b0;
      ev_unf_q     <= 1'b0;
      ev_inx_q     <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      inx_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_sum_q     <= s1_sum_d;
      s1_inexact_q <= s1_inexact_d;
      s1_nan_q     <= s1_nan_d;
      s1_inf_q     <= s1_inf_d;
      s1_zero_q    <= s1_zero_d;
      o_valid_q    <= o_valid_d;
      result_q     <= result_d;
      ev_ovf_q     <= ev_ovf_d;
      ev_unf_q     <= ev_unf_d;
      ev_inx_q     <= ev_inx_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      inx_q        <= inx_d;
    end
  end

  assign bus.o_valid     = o_valid_q;
  assign bus.o_result    = result_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = unf_q;
  assign bus.o_inexact   = inx_q;

endmodule

// File: doc/rounding_pack_unit.md
# rounding_pack_unit

Two-stage pipelined FP32 round-and-pack stage that sits directly downstream of the normalization stage. It takes the normalized 28-bit mantissa, the adjusted exponent and the special-case flags, and applies round-to-nearest-even. It then handles the rounding carry, exponent overflow and underflow, and packs the IEEE-754 single-precision result. Data moves through a valid/ready handshake with full backpressure, and the block keeps sticky exception flags.

## Interface
- SIZE_DATA, 28, normalized mantissa width: [27] hidden one, [26:4] fraction, [3] guard, [2:0] round/sticky bits
- SIZE_EXP, 10, signed two's-complement biased exponent width
- i_clk  in  1  clock; all registers on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  stage 1 can accept a beat
- i_sign  in  1  result sign
- i_exponent  in  SIZE_EXP  biased exponent after normalization adjust, signed
- i_mantissa  in  SIZE_DATA  normalized mantissa, output of the normalization stage
- i_zero_flag  in  1  exact-zero result
- i_nan_flag  in  1  NaN result
- i_inf_flag  in  1  infinite result
- o_valid  out  1  o_result valid
- i_ready  in  1  downstream accepts o_result
- o_result  out  32  packed FP32 {sign, exp[7:0], frac[22:0]}
- i_flag_clr  in  1  synchronous clear of the sticky flags
- o_overflow  out  1  sticky overflow flag
- o_underflow  out  1  sticky underflow flag
- o_inexact  out  1  sticky inexact flag

## Operation
- **Stage 1 (round)** captures on i_valid & o_ready.
  - lsb = m[4]; g = m[3]; s = |m[2:0]
  - inc = g & (s | lsb)
  - sum = {1'b0, m[27:4]} + inc, 25 bits
  - inexact = g | s
  - Registers sign, exponent, sum, inexact and the special flags.
- **Stage 2 (adjust/pack)**:
  - If sum[24] = 1: exp_r = exp + 1, frac = sum[23:1]; else exp_r = exp, frac = sum[22:0].
  - Priority, highest first:
    - nan → 32'h7FC00000 (canonical, sign ignored), no flags
    - inf → {sign, 8'hFF, 23'h0}, no flags
    - zero → {sign, 31'h0}, no flags
    - exp_r ≤ 0 → {sign, 31'h0} (flush, no subnormals); underflow = 1, inexact = 1
    - exp_r ≥ 255 → {sign, 8'hFF, 23'h0}; overflow = 1, inexact = 1
    - otherwise → {sign, exp_r[7:0], frac}; inexact as computed
- **Sticky flags**:
  - Each flag is ORed with the stage-2 event flags when a result retires (o_valid & i_ready).
  - i_flag_clr clears all three flags.
  - If a clear and a retire happen in the same cycle, the retiring event's flags are kept: clear first, then set.
- The block has no FSM. Each stage is a valid bit plus a data register.

## Timing
- Reset (async assert, sync release) sets all valid bits, o_valid, o_result (32'h0) and every sticky flag to 0. o_ready = 1 during reset.
- Latency is 2 cycles from input accept to o_valid. Throughput is 1 beat/cycle while i_ready = 1.
- Stage 2 advance: adv2 = !o_valid | i_ready.
- Stage 1 advance: adv1 = !s1_valid | adv2.
- o_ready = adv1, computed combinationally from i_ready; there is no skid buffer.
- With i_ready low, the pipeline holds two beats. o_ready falls once both stages are full.
- While o_valid & !i_ready, o_result is held stable.
- A beat moves into stage 2 on the same edge that the previous beat retires. No bubble is inserted.
- Reset asserted mid-operation discards all in-flight beats immediately. No partial output is produced.

## Test plan
- **Basic 1.0**: exp = 127, m = 28'h8000000 → o_result 32'h3F800000 two cycles after accept, no flags set.
- **Tie-to-even**:
  - m = 28'h8000008, exp 127 → 32'h3F800000, inexact = 1.
  - m = 28'h8000018 → 32'h3F800002.
- **Carry and overflow**:
  - m = 28'hFFFFFF8, exp 127 → 32'h40000000.
  - Same m with exp 254 → 32'h7F800000, overflow = 1, inexact = 1.
- **Underflow and specials**:
  - exp = 0, sign 1 → 32'h80000000, underflow = 1.
  - nan → 32'h7FC00000.
  - inf with sign 1 → 32'hFF800000.
  - zero with sign 0 → 32'h00000000.
- **Backpressure**: drive 4 back-to-back beats while i_ready = 0 for 3 cycles. Required response: o_ready deasserts after 2 beats are captured, o_result stays stable, all 4 results emerge in order with no loss or duplicates.
- **Flags and reset**:
  - i_flag_clr in the same cycle as an overflow retire leaves overflow = 1.
  - i_flag_clr alone clears all three flags.
  - Asserting i_rst_n = 0 with 2 beats in flight gives o_valid = 0 immediately, and no output appears after release.
